spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Two-requester round-robin arbiter and transaction sequencer for the shared `spi_master_2` byte engine. It accepts independent byte-transfer requests from two client blocks, each targeting slave 0 (cs1) or slave 1 (cs2). It issues one transfer at a time to the master, waits for completion, and returns the received slave byte to the requester that owns the transfer. It sits between the client logic and `spi_master_2`, and it is the only driver of the master's `data` and `slave_num` inputs.

## Interface
- `DW`, 8: transfer byte width.
- `TIMEOUT_CYCLES`, 255: watchdog limit in `clk` cycles; used only with `SPI_ARB_TIMEOUT_EN`; range 1..65535.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0` / `req1`  in  1  request from client 0/1; held high until the matching `gnt` pulse.
- `wdata0` / `wdata1`  in  DW  byte to send; must be stable while `req` is high.
- `slave0` / `slave1`  in  1  target slave (0 → cs1, 1 → cs2); must be stable while `req` is high.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: request accepted, and its data is now in the master.
- `done0` / `done1`  out  1  one-cycle pulse: `rdata` (and `err`) are valid for that client.
- `rdata`  out  DW  received byte; holds its value until the next response.
- `err`  out  1  timeout flag; valid with the `done` pulse; stays 0 when the watchdog is not compiled in.
- `m_ready`  in  1  master `can_write`: high when the master is idle and can accept a byte.
- `m_start`  out  1  one-cycle pulse that launches a master transfer.
- `m_data`  out  DW  byte to the master's `data`.
- `m_slave`  out  1  to the master's `slave_num`.
- `m_done`  in  1  one-cycle pulse from the master at end of transfer.
- `m_rx`  in  DW  master `slave_data`; valid in the cycle `m_done` is high.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE:** When `m_ready`=1 and any `req` is high, pick a winner, latch its `wdata`/`slave` into `m_data`/`m_slave`, record the owner, and go to ISSUE. If `m_ready`=0, stay in IDLE regardless of requests.
- **Arbitration:** Round-robin via a `last` pointer.
  - A single requester always wins.
  - When both request, the client ≠ `last` wins.
  - `last` updates to the winner on every grant.
  - `last` resets to 1, so client 0 wins the first tie.
- **ISSUE:** One cycle. `m_start`=1, and the owner's `gnt` is high in the same cycle. Go to WAIT.
- **WAIT:** On `m_done`=1, capture `m_rx` into `rdata`, clear `err`, and go to RESP. With the watchdog enabled, see Configuration.
- **RESP:** One cycle. The owner's `done` is high. Go to IDLE.
- `m_done` is ignored in IDLE, ISSUE and RESP.
- A requester that keeps `req` high after `gnt` is treated as a new request and re-arbitrated in the next IDLE.
- `m_data`/`m_slave` hold their values from latch until the next latch.
- **Reset (async, including mid-transfer):**
  - state → IDLE, `last` → 1.
  - All pulses (`gnt*`, `done*`, `m_start`) → 0.
  - `m_data` → 0, `m_slave` → 0, `rdata` → 0, `err` → 0.
  - An in-flight transfer is abandoned with no `done`.

## Timing
- From `req` sampled in IDLE (with `m_ready`=1) to `gnt`/`m_start`: 1 cycle.
- From `m_done` to `done`: 1 cycle; `rdata` is valid in the same cycle as `done`.
- Minimum spacing between successive `m_start` pulses: 3 cycles plus the master's transfer time. The next arbitration happens in the cycle after RESP, and only if `m_ready` is high.
- At most one transfer is outstanding. There is no queuing; requesters are back-pressured by withholding `gnt`.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments every cycle in WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `m_done`, go to RESP with `err`=1 and `rdata`=all-ones.
  - If `m_done` and the terminal count land in the same cycle, `m_done` wins and `err`=0.
- `SPI_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT lasts until `m_done`.
  - The `err` port still exists and is tied to 0.

## Test plan
- **Single request:** `req0`=1, `wdata0`=0x03, `slave0`=0, `m_ready`=1 → next cycle `gnt0`=`m_start`=1, `m_data`=0x03, `m_slave`=0. Then master returns `m_done` with `m_rx`=0xA5 → next cycle `done0`=1, `rdata`=0xA5, `err`=0.
- **Tie after reset:** `req0`=`req1`=1 held continuously → grants alternate 0,1,0,1; `m_slave` follows `slave0`=0 and `slave1`=1, so cs1 and cs2 alternate.
- **Back-pressure:** `m_ready`=0 with `req1`=1 for 10 cycles → no `gnt1` and no `m_start`. Raise `m_ready` → `gnt1` one cycle later.
- **Stray `m_done`:** `m_done` pulsed while in IDLE → no `done*` pulse and `rdata` unchanged.
- **Reset mid-WAIT:** assert `rst_n`=0 during WAIT → all outputs 0 immediately. After release, `req1`=`req0`=1 → client 0 granted first.
- **Timeout (with `SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20):** never send `m_done` → `done0` with `err`=1 and `rdata`=0xFF exactly 21 cycles after `m_start`. Without the macro, the FSM stays in WAIT indefinitely.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-client round-robin arbiter and transaction sequencer
// for the shared spi_master_2 byte engine. One transfer is outstanding
// at a time, and the received byte goes back to the client that owns it.
// Optional feature: define SPI_ARB_TIMEOUT_EN to compile in the WAIT
// watchdog. On expiry, err=1 and rdata is all-ones.
module spi_arbiter #(
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          slave0,
    input  logic          slave1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          err,
    input  logic          m_ready,
    output logic          m_start,
    output logic [DW-1:0] m_data,
    output logic          m_slave,
    input  logic          m_done,
    input  logic [DW-1:0] m_rx
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("spi_arbiter: TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last;     // client granted most recently
    logic          r_owner;    // client that owns the transfer in flight
    logic [DW-1:0] r_m_data;
    logic          r_m_slave;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          w_grant;
    logic          w_pick;
    logic          w_timeout;

    // A lone requester wins. On a tie, the client that did not win last time wins.
    assign w_pick  = (req0 && req1) ? ~r_last : req1;
    assign w_grant = (r_state == S_IDLE) && m_ready && (req0 || req1);

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Watchdog counter: cleared in ISSUE (the cycle before WAIT), counts in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == S_ISSUE)
            r_cnt <= '0;
        else if (r_state == S_WAIT)
            r_cnt <= r_cnt + 16'd1;
    end

    // Terminal count on the last WAIT cycle. A coincident m_done takes priority.
    assign w_timeout = (r_state == S_WAIT) && !m_done &&
                       (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (m_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch the winner's request on grant, and capture the response in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_m_data  <= '0;
            r_m_slave <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last    <= w_pick;
                r_owner   <= w_pick;
                r_m_data  <= w_pick ? wdata1 : wdata0;
                r_m_slave <= w_pick ? slave1 : slave0;
            end
            if (r_state == S_WAIT) begin
                if (m_done) begin
                    r_rdata <= m_rx;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rdata <= '1;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    // Pulses decode straight from the state register, so an async reset clears them at once
    assign m_start = (r_state == S_ISSUE);
    assign gnt0    = (r_state == S_ISSUE) && !r_owner;
    assign gnt1    = (r_state == S_ISSUE) &&  r_owner;
    assign done0   = (r_state == S_RESP)  && !r_owner;
    assign done1   = (r_state == S_RESP)  &&  r_owner;
    assign m_data  = r_m_data;
    assign m_slave = r_m_slave;
    assign rdata   = r_rdata;
    assign err     = r_err;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed testbench for spi_arbiter. Inputs are driven and
// outputs are sampled on the falling edge of clk.
module tb_spi_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [DW-1:0] wdata0, wdata1;
    logic          slave0, slave1;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata;
    logic          err;
    logic          m_ready;
    logic          m_start;
    logic [DW-1:0] m_data;
    logic          m_slave;
    logic          m_done;
    logic [DW-1:0] m_rx;

    int n_total = 0;
    int n_pass  = 0;

    spi_arbiter #(.DW(DW), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .wdata0(wdata0), .wdata1(wdata1),
        .slave0(slave0), .slave1(slave1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err),
        .m_ready(m_ready), .m_start(m_start),
        .m_data(m_data), .m_slave(m_slave),
        .m_done(m_done), .m_rx(m_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   {30'd0, gnt0, gnt1}, 32'd0);
        check({tag, "_done"},  {30'd0, done0, done1}, 32'd0);
        check({tag, "_start"}, {31'd0, m_start}, 32'd0);
        check({tag, "_mdata"}, {24'd0, m_data}, 32'd0);
        check({tag, "_mslv"},  {31'd0, m_slave}, 32'd0);
        check({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
        check({tag, "_err"},   {31'd0, err}, 32'd0);
    endtask

    // Wait (bounded) for m_start, check the grant, then complete the transfer with rx.
    task automatic xfer(input string tag, input bit client, input logic [7:0] data,
                        input bit slv, input logic [7:0] rx);
        bit found = 1'b0;
        for (int unsigned i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m_start) found = 1'b1;
        end
        check({tag, "_start_seen"}, {31'd0, found}, 32'd1);
        check({tag, "_gnt"},   {30'd0, gnt0, gnt1}, client ? 32'd1 : 32'd2);
        check({tag, "_mdata"}, {24'd0, m_data}, {24'd0, data});
        check({tag, "_mslv"},  {31'd0, m_slave}, {31'd0, slv});
        @(negedge clk);              // WAIT
        m_done = 1'b1;
        m_rx   = rx;
        @(negedge clk);              // RESP
        m_done = 1'b0;
        check({tag, "_done"},  {30'd0, done0, done1}, client ? 32'd1 : 32'd2);
        check({tag, "_rdata"}, {24'd0, rdata}, {24'd0, rx});
        check({tag, "_err"},   {31'd0, err}, 32'd0);
    endtask

    initial begin
        bit seen;
        int unsigned n;

        rst_n = 1'b0; req0 = 0; req1 = 0; wdata0 = '0; wdata1 = '0;
        slave0 = 0; slave1 = 0; m_ready = 0; m_done = 0; m_rx = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Tie after reset: grants alternate 0,1,0,1
        @(negedge clk);
        m_ready = 1; req0 = 1; req1 = 1;
        wdata0 = 8'h11; slave0 = 0; wdata1 = 8'h22; slave1 = 1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) xfer($sformatf("tie%0d", k), 1'b0, 8'h11, 1'b0, 8'h10 + 8'(k));
            else            xfer($sformatf("tie%0d", k), 1'b1, 8'h22, 1'b1, 8'h10 + 8'(k));
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

        // Single request: one-cycle latency to gnt0/m_start
        req0 = 1; wdata0 = 8'h03; slave0 = 0;
        @(negedge clk);
        check("single_start", {31'd0, m_start}, 32'd1);
        check("single_gnt",   {30'd0, gnt0, gnt1}, 32'd2);
        check("single_mdata", {24'd0, m_data}, 32'h03);
        check("single_mslv",  {31'd0, m_slave}, 32'd0);
        req0 = 0;
        @(negedge clk);
        check("single_start_low", {31'd0, m_start}, 32'd0);
        m_done = 1; m_rx = 8'hA5;
        @(negedge clk);
        m_done = 0;
        check("single_done",  {30'd0, done0, done1}, 32'd2);
        check("single_rdata", {24'd0, rdata}, 32'hA5);
        check("single_err",   {31'd0, err}, 32'd0);
        @(negedge clk);
        check("single_done_pulse", {30'd0, done0, done1}, 32'd0);
        check("single_rdata_hold", {24'd0, rdata}, 32'hA5);

        // Back-pressure: m_ready low blocks the grant
        m_ready = 0; req1 = 1; wdata1 = 8'h5C; slave1 = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt1 || m_start) seen = 1;
        end
        check("bp_no_grant", {31'd0, seen}, 32'd0);
        m_ready = 1;
        xfer("bp", 1'b1, 8'h5C, 1'b1, 8'h3C);
        req1 = 0;
        @(negedge clk);

        // Stray m_done in IDLE
        m_done = 1; m_rx = 8'h77;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1) seen = 1;
        end
        m_done = 0;
        check("stray_no_done", {31'd0, seen}, 32'd0);
        check("stray_rdata",   {24'd0, rdata}, 32'h3C);

        // Reset mid-WAIT
        req0 = 1; wdata0 = 8'h44; slave0 = 0;
        @(negedge clk);
        check("rst_pre_start", {31'd0, m_start}, 32'd1);
        req0 = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1;
        req0 = 1; req1 = 1; wdata0 = 8'h61; wdata1 = 8'h62; slave0 = 0; slave1 = 1;
        xfer("rst_after", 1'b0, 8'h61, 1'b0, 8'h5A);
        req0 = 0; req1 = 0;
        @(negedge clk);

        // Watchdog behaviour
        req0 = 1; wdata0 = 8'h99; slave0 = 0;
        @(negedge clk);
        check("to_start", {31'd0, m_start}, 32'd1);
        req0 = 0;
        n = 0; seen = 0;
        for (int unsigned i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                seen = 1;
                n = i;
            end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        check("to_seen",   {31'd0, seen}, 32'd1);
        check("to_cycles", n, 32'd21);
        check("to_err",    {31'd0, err}, 32'd1);
        check("to_rdata",  {24'd0, rdata}, 32'hFF);
`else
        check("to_no_done", {31'd0, seen}, 32'd0);
        check("to_err0",    {31'd0, err}, 32'd0);
        m_done = 1; m_rx = 8'hC3;
        @(negedge clk);
        m_done = 0;
        check("to_late_done",  {30'd0, done0, done1}, 32'd2);
        check("to_late_rdata", {24'd0, rdata}, 32'hC3);
`endif
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
